// File: rtl/memory_rndgen_lat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory_rndgen_lat: self-filling PDP-8 memory model with LFSR generation,  |
// | pipelined read latency, write port and generation statistics.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module memory_rndgen_lat #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 12,
    parameter int          RD_LATENCY = 1,
    parameter int          MEM_WEIGHT = 1,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic [ADDR_WIDTH:0]   gen_count,
    output logic [ADDR_WIDTH:0]   mem_op_count
);

    localparam int                DEPTH      = 2**ADDR_WIDTH;
    localparam logic [15:0]       LFSR_TAPS  = 16'hB400;
    localparam logic [4:0]        WEIGHT     = 5'(MEM_WEIGHT);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]                  mem_q [DEPTH];
    logic [DEPTH-1:0]                       valid_q;
    logic [15:0]                            lfsr_q, lfsr_d;
    logic [ADDR_WIDTH:0]                    gen_cnt_q, mop_cnt_q;
    logic [RD_LATENCY-1:0]                  pipe_vld_q;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0]  pipe_data_q;

    logic                  rd_hit;
    logic                  gen_en;
    logic                  gen_is_mem;
    logic [2:0]            gen_op;
    logic [DATA_WIDTH-1:0] gen_word;
    logic [DATA_WIDTH-1:0] rd_word;

    // Lookup sees pre-write state, so a same-cycle write never bypasses into the read.
    always_comb begin
        rd_hit     = valid_q[ifu_rd_addr];
        gen_en     = ifu_rd_req && !rd_hit;
        gen_is_mem = ({1'b0, lfsr_q[3:0]} < WEIGHT);
        if (!gen_is_mem) begin
            gen_op = 3'd7;
        end else if (lfsr_q[6:4] < 3'd6) begin
            gen_op = lfsr_q[6:4];
        end else begin
            gen_op = lfsr_q[6:4] - 3'd6;
        end
        gen_word = {gen_op, lfsr_q[15 -: DATA_WIDTH-3]};
        rd_word  = rd_hit ? mem_q[ifu_rd_addr] : gen_word;
        lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Write port is applied after generation so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (gen_en) begin
                mem_q[ifu_rd_addr] <= gen_word;
            end
            if (exec_wr_req) begin
                mem_q[exec_wr_addr] <= exec_wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            lfsr_q    <= SEED;
            gen_cnt_q <= '0;
            mop_cnt_q <= '0;
        end else begin
            if (gen_en) begin
                valid_q[ifu_rd_addr] <= 1'b1;
                lfsr_q               <= lfsr_d;
                if (gen_cnt_q != '1) begin
                    gen_cnt_q <= gen_cnt_q + CNT_ONE;
                end
                if (gen_is_mem && (mop_cnt_q != '1)) begin
                    mop_cnt_q <= mop_cnt_q + CNT_ONE;
                end
            end
            if (exec_wr_req) begin
                valid_q[exec_wr_addr] <= 1'b1;
            end
        end
    end

    // Data stages only advance with their valid bit, so the last stage holds its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_q  <= '0;
            pipe_data_q <= '0;
        end else begin
            pipe_vld_q[0] <= ifu_rd_req;
            if (ifu_rd_req) begin
                pipe_data_q[0] <= rd_word;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                if (pipe_vld_q[k-1]) begin
                    pipe_data_q[k] <= pipe_data_q[k-1];
                end
            end
        end
    end

    assign ifu_rd_valid = pipe_vld_q[RD_LATENCY-1];
    assign ifu_rd_data  = pipe_data_q[RD_LATENCY-1];
    assign gen_count    = gen_cnt_q;
    assign mem_op_count = mop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_rndgen_lat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memory_rndgen_lat: directed bench over four parameterisations sharing  |
// | one stimulus stream.                                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_memory_rndgen_lat;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [11:0] wr_data;

    logic [11:0] d1, d3, d16, d0;
    logic        v1, v3, v16, v0;
    logic [12:0] g1, g3, g16, g0;
    logic [12:0] m1, m3, m16, m0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    memory_rndgen_lat u_lat1 (
        .clk(clk), .reset(reset),
        .ifu_rd_req(rd_req), .ifu_rd_addr(rd_addr), .ifu_rd_data(d1), .ifu_rd_valid(v1),
        .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
        .gen_count(g1), .mem_op_count(m1)
    );

    memory_rndgen_lat #(.RD_LATENCY(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .ifu_rd_req(rd_req), .ifu_rd_addr(rd_addr), .ifu_rd_data(d3), .ifu_rd_valid(v3),
        .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
        .gen_count(g3), .mem_op_count(m3)
    );

    memory_rndgen_lat #(.MEM_WEIGHT(16)) u_w16 (
        .clk(clk), .reset(reset),
        .ifu_rd_req(rd_req), .ifu_rd_addr(rd_addr), .ifu_rd_data(d16), .ifu_rd_valid(v16),
        .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
        .gen_count(g16), .mem_op_count(m16)
    );

    memory_rndgen_lat #(.MEM_WEIGHT(0)) u_w0 (
        .clk(clk), .reset(reset),
        .ifu_rd_req(rd_req), .ifu_rd_addr(rd_addr), .ifu_rd_data(d0), .ifu_rd_valid(v0),
        .exec_wr_req(wr_req), .exec_wr_addr(wr_addr), .exec_wr_data(wr_data),
        .gen_count(g0), .mem_op_count(m0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        tick();
        // A request presented during reset must be ignored.
        rd_req  = 1'b1;
        rd_addr = 12'o0005;
        tick();
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_data",  32'(d1), 32'd0);
        chk("rst_gen",   32'(g1), 32'd0);
        chk("rst_mop",   32'(m1), 32'd0);

        // First generation: op7 word from the seed.
        reset   = 1'b0;
        rd_addr = 12'o0000;
        tick();
        chk("rd0_valid", 32'(v1), 32'd1);
        chk("rd0_data",  32'(d1), 32'o7531);
        chk("rd0_gen",   32'(g1), 32'd1);
        chk("rd0_mop",   32'(m1), 32'd0);
        chk("lat3_not_yet_a", 32'(v3), 32'd0);

        rd_addr = 12'o0001;
        tick();
        chk("rd1_data", 32'(d1), 32'o1704);
        chk("rd1_gen",  32'(g1), 32'd2);
        chk("rd1_mop",  32'(m1), 32'd1);
        chk("lat3_not_yet_b", 32'(v3), 32'd0);

        rd_addr = 12'o0000;
        tick();
        chk("reread0_data", 32'(d1), 32'o7531);
        chk("reread0_gen",  32'(g1), 32'd2);
        chk("lat3_first_valid", 32'(v3), 32'd1);
        chk("lat3_first_data",  32'(d3), 32'o7531);

        // Write then read back; idle cycle must drop valid and hold data.
        rd_req  = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 12'o0100;
        wr_data = 12'o4321;
        tick();
        chk("idle_valid", 32'(v1), 32'd0);
        chk("idle_hold",  32'(d1), 32'o7531);
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 12'o0100;
        tick();
        chk("raw_data", 32'(d1), 32'o4321);
        chk("raw_gen",  32'(g1), 32'd2);

        // Same-cycle read/write collision on an unwritten address.
        rd_addr = 12'o0200;
        wr_req  = 1'b1;
        wr_addr = 12'o0200;
        wr_data = 12'o1111;
        tick();
        chk("coll_valid", 32'(v1), 32'd1);
        chk("coll_data",  32'(d1), 32'o7342);
        chk("coll_gen",   32'(g1), 32'd3);
        wr_req = 1'b0;
        tick();
        chk("coll_after_data", 32'(d1), 32'o1111);
        chk("coll_after_gen",  32'(g1), 32'd3);

        // Latency 3: preload known words, then four back-to-back reads.
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_req  = 1'b1;
            wr_addr = 12'o0010 + 12'(i);
            wr_data = 12'o5010 + 12'(i);
            tick();
        end
        wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = 12'o0010 + 12'(i);
            tick();
            if (i < 2) begin
                chk("lat3_early_valid", 32'(v3), 32'd0);
            end else begin
                chk("lat3_burst_valid", 32'(v3), 32'd1);
                chk("lat3_burst_data",  32'(d3), 32'o5010 + 32'(i - 2));
            end
        end
        rd_req = 1'b0;
        tick();
        chk("lat3_burst_valid", 32'(v3), 32'd1);
        chk("lat3_burst_data",  32'(d3), 32'o5012);
        tick();
        chk("lat3_burst_valid", 32'(v3), 32'd1);
        chk("lat3_burst_data",  32'(d3), 32'o5013);
        tick();
        chk("lat3_burst_end",  32'(v3), 32'd0);
        chk("lat3_burst_hold", 32'(d3), 32'o5013);

        // Reset with two reads in flight must flush them.
        rd_req  = 1'b1;
        rd_addr = 12'o0020;
        tick();
        rd_addr = 12'o0021;
        tick();
        reset   = 1'b1;
        rd_addr = 12'o0005;
        tick();
        reset  = 1'b0;
        rd_req = 1'b0;
        chk("flush_valid", 32'(v3), 32'd0);
        chk("flush_data",  32'(d3), 32'd0);
        chk("flush_gen",   32'(g3), 32'd0);
        chk("flush_mop",   32'(m3), 32'd0);
        tick();
        chk("flush_valid_b", 32'(v3), 32'd0);
        tick();
        chk("flush_valid_c", 32'(v3), 32'd0);

        rd_req  = 1'b1;
        rd_addr = 12'o0000;
        tick();
        rd_req = 1'b0;
        chk("reseed_data",  32'(d1), 32'o7531);
        chk("reseed_valid", 32'(v1), 32'd1);
        chk("reseed_gen",   32'(g1), 32'd1);
        tick();
        tick();
        chk("reseed_lat3_valid", 32'(v3), 32'd1);
        chk("reseed_lat3_data",  32'(d3), 32'o7531);

        // Opcode mix extremes over 64 distinct addresses.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rd_req  = 1'b1;
            rd_addr = 12'(i);
            tick();
            chk("w16_opcode_le5", 32'(d16[11:9] <= 3'd5), 32'd1);
            chk("w0_opcode_7",    32'(d0[11:9]), 32'd7);
        end
        rd_req = 1'b0;
        chk("w16_gen", 32'(g16), 32'd64);
        chk("w16_mop", 32'(m16), 32'd64);
        chk("w0_gen",  32'(g0),  32'd64);
        chk("w0_mop",  32'(m0),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_rndgen_lat.md
Name: memory_rndgen_lat

Overview:
Parametrised self-generating memory model for PDP-8 instruction-fetch and execute benches. Each unwritten address is filled on its first read with a pseudo-random instruction word from a seeded LFSR, so every run is reproducible. The block adds:
- a configurable read latency with a valid strobe;
- a write port with an explicit collision rule;
- a tunable memory-op/op7 mix;
- generation statistics.
It sits where the fetch-side memory model sits, between the IFU and the bench.

Parameters:
ADDR_WIDTH, 12, address bits; storage depth is 2**ADDR_WIDTH words
DATA_WIDTH, 12, word bits; legal range 4..12
RD_LATENCY, 1, cycles from accepted read request to ifu_rd_valid; legal range 1..4
MEM_WEIGHT, 1, out of 16; probability weight of generating a memory-reference opcode (0..16)
SEED, 16'hACE1, LFSR value loaded at reset; must be non-zero

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
ifu_rd_req  input  1  read request; one request accepted every cycle it is high
ifu_rd_addr  input  ADDR_WIDTH  read address, sampled with ifu_rd_req
ifu_rd_data  output  DATA_WIDTH  read data; qualified by ifu_rd_valid, holds last value otherwise
ifu_rd_valid  output  1  one-cycle pulse per accepted request, RD_LATENCY cycles after it
exec_wr_req  input  1  write strobe
exec_wr_addr  input  ADDR_WIDTH  write address
exec_wr_data  input  DATA_WIDTH  write data
gen_count  output  ADDR_WIDTH+1  number of words generated since reset; saturating
mem_op_count  output  ADDR_WIDTH+1  number of generated words with opcode 0..5; saturating

Behaviour:
- Storage: 2**ADDR_WIDTH-word array plus a per-address valid bitmap.
- Reset (synchronous, any cycle):
  - clears all valid bits; array contents don't-care;
  - loads LFSR with SEED;
  - flushes the read pipeline, so no ifu_rd_valid is issued for requests in flight;
  - ifu_rd_valid=0, ifu_rd_data=0, gen_count=0, mem_op_count=0.
  - Requests and writes presented during reset are ignored.
- LFSR: 16-bit Galois, right-shift, tap mask 16'hB400.
  - next = (L>>1) ^ (L[0] ? 16'hB400 : 0).
  - Advances only on a generation event, exactly once per generation.
- Read accepted at cycle T:
  - If the address is valid, data = stored word.
  - Otherwise generate from the current LFSR value L:
    - if L[3:0] < MEM_WEIGHT: opcode = L[6:4] when < 6, else L[6:4]-6; mem_op_count increments;
    - else opcode = 7;
    - word = {opcode, L[15 -: DATA_WIDTH-3]}.
  - A generated word is stored, its valid bit is set, gen_count increments, and the LFSR advances, all at edge T.
  - Data is presented with ifu_rd_valid=1 at cycle T+RD_LATENCY.
  - With RD_LATENCY=1, data appears on the cycle after the request.
- Back-to-back reads: fully pipelined, one response per request, in order; no stalls.
- Write: on exec_wr_req, the word is stored and its valid bit set at the clock edge. Read-after-write to the same address in a later cycle returns the written data.
- Same-cycle read and write to the same address:
  - the read returns the pre-write content, or a generated word if the address was invalid;
  - the write wins in storage, so a later read returns exec_wr_data;
  - a generation in that cycle still advances the LFSR and counters.
- Same-cycle read and write to different addresses: independent.
- Counters saturate at all-ones; they never wrap.
- MEM_WEIGHT=0 gives only op7 words; MEM_WEIGHT=16 gives only opcodes 0..5.
- A repeat read of a generated address returns the identical word and does not advance the LFSR.

Test Plan:
- Reset, default parameters, read addr 'o0000 at T → ifu_rd_valid=1 at T+1 with ifu_rd_data='o7531; gen_count=1; mem_op_count=0.
- Then read 'o0001 → data 'o1704 (memory op, opcode 1); gen_count=2; mem_op_count=1. Re-read 'o0000 → 'o7531 and gen_count stays 2.
- Write 'o4321 to 'o0100, next cycle read 'o0100 → 'o4321 with gen_count unchanged. Then a same-cycle read and write of 'o0200 (unwritten) with data 'o1111 → read returns the generated word; a later read returns 'o1111.
- RD_LATENCY=3, reads on 4 consecutive cycles to 'o10..'o13 → four valid pulses on consecutive cycles starting 3 cycles after the first request, in address order.
- Reset asserted with 2 reads in flight (RD_LATENCY=3) → no ifu_rd_valid afterwards; counters=0. Re-reading 'o0000 returns 'o7531 again, confirming the LFSR reloaded from SEED.
- MEM_WEIGHT=16, 64 reads of distinct addresses → every opcode is ≤5 and mem_op_count=gen_count=64. MEM_WEIGHT=0 → every opcode is 7 and mem_op_count=0.
